// File: rtl/glossy_rx_pkg.sv
// Shared encodings and buffer layout constants for the Glossy frame-buffer reader.
package glossy_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LEN,
    ST_CHK_LEN,
    ST_RD_BODY,
    ST_UPDATE
  } state_e;

  localparam int OFS_LEN     = 0;
  localparam int OFS_RLY     = 1;
  localparam int OFS_PAYLOAD = 2;
  localparam int FCS_OK_BIT  = 7;

  // LEN must cover relay, payload, RSSI and status bytes.
  function automatic int min_len(input int payload_bytes);
    return payload_bytes + 3;
  endfunction

  localparam int MIN_LEN_DFLT = min_len(4);

endpackage

// File: rtl/glossy_rx_seq_tracker.sv
// Frame-counter continuity tracker: keeps the last good counter as a baseline and
// reports how many frames went missing before the current one (clamped to CNT_W).
module glossy_rx_seq_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [31:0]      i_cnt,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_lost_inc
);

  localparam logic [31:0] INC_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [31:0] last_q, last_d;
  logic        base_vld_q, base_vld_d;
  logic [31:0] gap;

  always_comb begin
    gap        = i_cnt - last_q - 32'd1;
    o_lost_inc = '0;
    last_d     = last_q;
    base_vld_d = base_vld_q;
    // A counter at or below the baseline (duplicate, restart or wrap) just rebaselines.
    if (i_valid && base_vld_q && (i_cnt > last_q)) begin
      o_lost_inc = (gap > INC_MAX) ? INC_MAX[CNT_W-1:0] : gap[CNT_W-1:0];
    end
    if (i_clear) begin
      base_vld_d = 1'b0;
    end else if (i_valid) begin
      last_d     = i_cnt;
      base_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= '0;
      base_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      base_vld_q <= base_vld_d;
    end
  end

endmodule

// File: rtl/glossy_rx_reader.sv
// Drains a received Glossy frame from the buffer after each phase, parses its fields
// and keeps saturating reception statistics.
module glossy_rx_reader
  import glossy_rx_pkg::*;
#(
  parameter int ADDR_W        = 7,
  parameter int MAX_LEN       = 127,
  parameter int PAYLOAD_BYTES = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_glossy_done,
  input  logic              i_t_cnt_ref_updated,
  input  logic              i_clear,
  output logic [ADDR_W-1:0] o_buf_r_addr,
  input  logic [7:0]        i_buf_r_byte,
  output logic              o_busy,
  output logic              o_frm_valid,
  output logic [31:0]       o_frm_cnt,
  output logic [7:0]        o_relay_cnt,
  output logic [7:0]        o_rssi,
  output logic [CNT_W-1:0]  o_n_rx_ok,
  output logic [CNT_W-1:0]  o_n_lost,
  output logic [CNT_W-1:0]  o_n_miss,
  output logic [CNT_W-1:0]  o_n_err
);

  localparam logic [7:0] LEN_MIN = 8'(min_len(PAYLOAD_BYTES));
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  cap_addr_q, cap_addr_d;
  logic               cap_vld_q, cap_vld_d;
  logic [7:0]         len_q, len_d;
  logic               len_err_q, len_err_d;
  logic               done_q, done_d;
  logic [7:0]         relay_s_q, relay_s_d;
  logic [7:0]         rssi_s_q, rssi_s_d;
  logic [31:0]        cnt_s_q, cnt_s_d;
  logic               frm_valid_q, frm_valid_d;
  logic [31:0]        frm_cnt_q, frm_cnt_d;
  logic [7:0]         relay_q, relay_d;
  logic [7:0]         rssi_q, rssi_d;
  logic [CNT_W-1:0]   n_rx_ok_q, n_rx_ok_d;
  logic [CNT_W-1:0]   n_lost_q, n_lost_d;
  logic [CNT_W-1:0]   n_miss_q, n_miss_d;
  logic [CNT_W-1:0]   n_err_q, n_err_d;
  logic               rise, frame_good, miss_hit, err_hit;
  logic [CNT_W-1:0]   lost_inc;

  assign rise = i_glossy_done & ~done_q;

  glossy_rx_seq_tracker #(.CNT_W(CNT_W)) u_seq (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (frame_good),
    .i_cnt      (cnt_s_q),
    .i_clear    (i_clear),
    .o_lost_inc (lost_inc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    len_err_d   = len_err_q;
    done_d      = i_glossy_done;
    relay_s_d   = relay_s_q;
    rssi_s_d    = rssi_s_q;
    cnt_s_d     = cnt_s_q;
    frm_valid_d = 1'b0;
    frm_cnt_d   = frm_cnt_q;
    relay_d     = relay_q;
    rssi_d      = rssi_q;
    frame_good  = 1'b0;
    miss_hit    = 1'b0;
    err_hit     = 1'b0;
    cap_vld_d   = (state_q == ST_RD_BODY);
    cap_addr_d  = addr_q;

    // Read data lags the address by one cycle, so capture by the address issued last cycle.
    if (cap_vld_q) begin
      if (cap_addr_q == ADDR_W'(OFS_RLY)) relay_s_d = i_buf_r_byte;
      for (int b = 0; b < 4; b++) begin
        if (cap_addr_q == ADDR_W'(OFS_PAYLOAD + b)) cnt_s_d[8*b +: 8] = i_buf_r_byte;
      end
      if (cap_addr_q == ADDR_W'(len_q - 8'd1)) rssi_s_d = i_buf_r_byte;
    end

    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (rise) begin
          if (i_t_cnt_ref_updated) state_d = ST_RD_LEN;
          else                     miss_hit = 1'b1;
        end
      end
      ST_RD_LEN: begin
        addr_d  = ADDR_W'(OFS_LEN);
        state_d = ST_CHK_LEN;
      end
      ST_CHK_LEN: begin
        len_d = i_buf_r_byte;
        if ((i_buf_r_byte < LEN_MIN) || (i_buf_r_byte > LEN_MAX)) begin
          len_err_d = 1'b1;
          state_d   = ST_UPDATE;
        end else begin
          len_err_d = 1'b0;
          addr_d    = ADDR_W'(OFS_RLY);
          state_d   = ST_RD_BODY;
        end
      end
      ST_RD_BODY: begin
        if (addr_q == ADDR_W'(len_q)) begin
          addr_d  = '0;
          state_d = ST_UPDATE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_UPDATE: begin
        // On the legal-LEN path the status byte is on the read bus this cycle.
        state_d = ST_IDLE;
        if (!len_err_q && i_buf_r_byte[FCS_OK_BIT]) begin
          frame_good  = 1'b1;
          frm_valid_d = 1'b1;
          frm_cnt_d   = cnt_s_q;
          relay_d     = relay_s_q;
          rssi_d      = rssi_s_q;
        end else begin
          err_hit = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    n_rx_ok_d = i_clear ? '0 : (frame_good ? sat_add(n_rx_ok_q, CNT_W'(1)) : n_rx_ok_q);
    n_lost_d  = i_clear ? '0 : sat_add(n_lost_q, lost_inc);
    n_miss_d  = i_clear ? '0 : (miss_hit ? sat_add(n_miss_q, CNT_W'(1)) : n_miss_q);
    n_err_d   = i_clear ? '0 : (err_hit ? sat_add(n_err_q, CNT_W'(1)) : n_err_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cap_addr_q  <= '0;
      cap_vld_q   <= 1'b0;
      len_q       <= '0;
      len_err_q   <= 1'b0;
      done_q      <= 1'b0;
      relay_s_q   <= '0;
      rssi_s_q    <= '0;
      cnt_s_q     <= '0;
      frm_valid_q <= 1'b0;
      frm_cnt_q   <= '0;
      relay_q     <= '0;
      rssi_q      <= '0;
      n_rx_ok_q   <= '0;
      n_lost_q    <= '0;
      n_miss_q    <= '0;
      n_err_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cap_addr_q  <= cap_addr_d;
      cap_vld_q   <= cap_vld_d;
      len_q       <= len_d;
      len_err_q   <= len_err_d;
      done_q      <= done_d;
      relay_s_q   <= relay_s_d;
      rssi_s_q    <= rssi_s_d;
      cnt_s_q     <= cnt_s_d;
      frm_valid_q <= frm_valid_d;
      frm_cnt_q   <= frm_cnt_d;
      relay_q     <= relay_d;
      rssi_q      <= rssi_d;
      n_rx_ok_q   <= n_rx_ok_d;
      n_lost_q    <= n_lost_d;
      n_miss_q    <= n_miss_d;
      n_err_q     <= n_err_d;
    end
  end

  assign o_buf_r_addr = addr_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frm_valid  = frm_valid_q;
  assign o_frm_cnt    = frm_cnt_q;
  assign o_relay_cnt  = relay_q;
  assign o_rssi       = rssi_q;
  assign o_n_rx_ok    = n_rx_ok_q;
  assign o_n_lost     = n_lost_q;
  assign o_n_miss     = n_miss_q;
  assign o_n_err      = n_err_q;

endmodule

// File: tb/tb_glossy_rx_reader.sv
// Directed bench for glossy_rx_reader: a byte-array buffer model with one-cycle read
// latency and hand-computed expectations for each phase.
module tb_glossy_rx_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_glossy_done;
  logic        i_t_cnt_ref_updated;
  logic        i_clear;
  logic [6:0]  o_buf_r_addr;
  logic [7:0]  i_buf_r_byte;
  logic        o_busy;
  logic        o_frm_valid;
  logic [31:0] o_frm_cnt;
  logic [7:0]  o_relay_cnt;
  logic [7:0]  o_rssi;
  logic [15:0] o_n_rx_ok;
  logic [15:0] o_n_lost;
  logic [15:0] o_n_miss;
  logic [15:0] o_n_err;

  logic [7:0]  mem [0:127];
  int          n_vec = 0;
  int          n_bad = 0;
  int          lat, busy_n;
  bit          seen, addr_nz, found;

  glossy_rx_reader u_dut (
    .clk                 (clk),
    .reset               (reset),
    .i_glossy_done       (i_glossy_done),
    .i_t_cnt_ref_updated (i_t_cnt_ref_updated),
    .i_clear             (i_clear),
    .o_buf_r_addr        (o_buf_r_addr),
    .i_buf_r_byte        (i_buf_r_byte),
    .o_busy              (o_busy),
    .o_frm_valid         (o_frm_valid),
    .o_frm_cnt           (o_frm_cnt),
    .o_relay_cnt         (o_relay_cnt),
    .o_rssi              (o_rssi),
    .o_n_rx_ok           (o_n_rx_ok),
    .o_n_lost            (o_n_lost),
    .o_n_miss            (o_n_miss),
    .o_n_err             (o_n_err)
  );

  // clock / buffer model
  always #5 clk = ~clk;
  always @(posedge clk) i_buf_r_byte <= mem[o_buf_r_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_frame(input int len, input logic [7:0] rly, input logic [31:0] cnt,
                            input logic [7:0] rssi, input logic [7:0] st);
    mem[0] = len[7:0];
    mem[1] = rly;
    mem[2] = cnt[7:0];
    mem[3] = cnt[15:8];
    mem[4] = cnt[23:16];
    mem[5] = cnt[31:24];
    if (len >= 7 && len <= 127) begin
      for (int a = 6; a < len - 1; a++) mem[a] = 8'hEE;
      mem[len-1] = rssi;
      mem[len]   = st;
    end
  endtask

  // One Glossy phase: done edge at cycle T; c counts cycles T+1, T+2, ...
  task automatic run_phase(input bit ref_upd, input int hold, input int clear_at);
    bit fin;
    @(negedge clk);
    i_t_cnt_ref_updated = ref_upd;
    i_glossy_done = 1'b1;
    @(posedge clk);
    fin = 1'b0; lat = 0; busy_n = 0; seen = 1'b0; addr_nz = 1'b0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clk);
      if (c >= hold) i_glossy_done = 1'b0;
      i_clear = (clear_at != 0) && (c == clear_at);
      if (o_busy) busy_n++;
      if (o_buf_r_addr != 7'd0) addr_nz = 1'b1;
      if (o_frm_valid) begin seen = 1'b1; lat = c; end
      if (!o_busy && c >= hold) fin = 1'b1;
    end
    i_clear = 1'b0;
    if (!fin) check("phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_frame(input int len, input logic [7:0] rly, input logic [31:0] cnt,
                          input logic [7:0] rssi, input logic [7:0] st, input int clear_at);
    load_frame(len, rly, cnt, rssi, st);
    run_phase(1'b1, 1, clear_at);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) mem[a] = 8'h00;
    reset = 1'b1; i_glossy_done = 1'b0; i_t_cnt_ref_updated = 1'b0; i_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_valid", 32'(o_frm_valid), 0);
    check("rst_addr", 32'(o_buf_r_addr), 0);
    check("rst_cnt", o_frm_cnt, 0);
    check("rst_stats", {o_n_rx_ok | o_n_lost, o_n_miss | o_n_err}, 0);
    reset = 1'b0;

    // Frame A: minimum legal LEN
    do_frame(7, 8'd3, 32'h10, 8'hC8, 8'h80, 0);
    check("a_seen", 32'(seen), 1);
    check("a_latency", lat, 11);
    check("a_busy_cycles", busy_n, 10);
    check("a_frm_cnt", o_frm_cnt, 32'h10);
    check("a_relay", 32'(o_relay_cnt), 3);
    check("a_rssi", 32'(o_rssi), 32'hC8);
    check("a_rx_ok", 32'(o_n_rx_ok), 1);
    check("a_lost", 32'(o_n_lost), 0);
    @(negedge clk);
    check("a_pulse_1cyc", 32'(o_frm_valid), 0);

    // Frame B: LEN 9 with extra payload, gap of 3
    do_frame(9, 8'd4, 32'h14, 8'hB0, 8'hFF, 0);
    check("b_latency", lat, 13);
    check("b_frm_cnt", o_frm_cnt, 32'h14);
    check("b_relay", 32'(o_relay_cnt), 4);
    check("b_rssi", 32'(o_rssi), 32'hB0);
    check("b_lost", 32'(o_n_lost), 3);

    do_frame(7, 8'd1, 32'h14, 8'h50, 8'h80, 0);
    check("dup_lost", 32'(o_n_lost), 3);
    check("dup_rx_ok", 32'(o_n_rx_ok), 3);

    do_frame(7, 8'd9, 32'h99, 8'h11, 8'h00, 0);
    check("fcs_no_pulse", 32'(seen), 0);
    check("fcs_err", 32'(o_n_err), 1);
    check("fcs_cnt_kept", o_frm_cnt, 32'h14);
    check("fcs_relay_kept", 32'(o_relay_cnt), 1);

    do_frame(2, 8'd0, 32'h0, 8'h0, 8'h0, 0);
    check("len2_no_pulse", 32'(seen), 0);
    check("len2_err", 32'(o_n_err), 2);
    check("len2_busy", busy_n, 3);

    do_frame(128, 8'd0, 32'h0, 8'h0, 8'h0, 0);
    check("len128_err", 32'(o_n_err), 3);
    check("len128_no_pulse", 32'(seen), 0);

    do_frame(127, 8'd2, 32'h15, 8'h7A, 8'h80, 0);
    check("len127_latency", lat, 131);
    check("len127_rssi", 32'(o_rssi), 32'h7A);
    check("len127_lost", 32'(o_n_lost), 3);
    check("len127_rx_ok", 32'(o_n_rx_ok), 4);

    for (int k = 0; k < 3; k++) begin
      run_phase(1'b0, 1, 0);
      check("miss_addr_idle", 32'(addr_nz), 0);
    end
    check("miss3", 32'(o_n_miss), 3);
    run_phase(1'b0, 20, 0);
    check("miss_held_single", 32'(o_n_miss), 4);

    do_frame(7, 8'd0, 32'h0, 8'h0, 8'h80, 0);
    check("rebase0_lost", 32'(o_n_lost), 3);
    do_frame(7, 8'd0, 32'h0010_0000, 8'h0, 8'h80, 0);
    check("lost_sat", 32'(o_n_lost), 32'hFFFF);
    check("sat_rx_ok", 32'(o_n_rx_ok), 6);

    @(negedge clk); i_clear = 1'b1;
    @(negedge clk); i_clear = 1'b0;
    check("clr_stats", {o_n_rx_ok | o_n_lost, o_n_miss | o_n_err}, 0);

    do_frame(7, 8'd0, 32'hFFFF_FFFF, 8'h0, 8'h80, 0);
    check("wrap_base_lost", 32'(o_n_lost), 0);
    do_frame(7, 8'd0, 32'h0, 8'h0, 8'h80, 0);
    check("wrap_lost", 32'(o_n_lost), 0);
    do_frame(7, 8'd0, 32'h2, 8'h0, 8'h80, 0);
    check("after_wrap_lost", 32'(o_n_lost), 1);
    check("after_wrap_rx_ok", 32'(o_n_rx_ok), 3);

    // Reset while in RD_BODY
    load_frame(7, 8'd5, 32'h77, 8'h33, 8'h80);
    @(negedge clk);
    i_t_cnt_ref_updated = 1'b1; i_glossy_done = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (o_buf_r_addr == 7'd4) found = 1'b1;
    end
    check("reach_addr4", 32'(found), 1);
    reset = 1'b1; i_glossy_done = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(o_busy), 0);
    check("mid_rst_addr", 32'(o_buf_r_addr), 0);
    check("mid_rst_fields", o_frm_cnt | {16'd0, o_relay_cnt, o_rssi}, 0);
    check("mid_rst_stats", {o_n_rx_ok | o_n_lost, o_n_miss | o_n_err}, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_frm_valid || o_busy) seen = 1'b1;
    end
    check("mid_rst_quiet", 32'(seen), 0);

    // Clear coinciding with a good frame's update cycle
    do_frame(7, 8'd0, 32'h5, 8'h0, 8'h80, 0);
    check("pre_clr_rx_ok", 32'(o_n_rx_ok), 1);
    do_frame(7, 8'd6, 32'h9, 8'h0, 8'h80, 10);
    check("clr_same_seen", 32'(seen), 1);
    check("clr_same_cnt", o_frm_cnt, 32'h9);
    check("clr_same_rx_ok", 32'(o_n_rx_ok), 0);
    check("clr_same_lost", 32'(o_n_lost), 0);
    do_frame(7, 8'd0, 32'hC, 8'h0, 8'h80, 0);
    check("clr_rebase_lost", 32'(o_n_lost), 0);
    check("clr_rebase_rx_ok", 32'(o_n_rx_ok), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
